pooling_stream: RTL
===================

POOLING_STREAM -- requirements
Module: pooling_stream

Interface
REQ-001 Parameter DATA_WIDTH, 8, unsigned pixel width.
REQ-002 Parameter IMG_WIDTH, 28, input pixels per row; even, >=2.
REQ-003 Parameter IMG_HEIGHT, 28, input rows per frame; even, >=2.
REQ-004 Port clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port mode  input  1  1 = max pooling, 0 = average pooling.
REQ-007 Port in_valid  input  1  in_data holds a valid pixel.
REQ-008 Port in_ready  output  1  block accepts a pixel this cycle.
REQ-009 Port in_data  input  DATA_WIDTH  unsigned pixel, raster order (row-major).
REQ-010 Port out_valid  output  1  out_data holds a pooled result.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port out_data  output  DATA_WIDTH  pooled pixel, raster order.
REQ-013 Port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-014 Transfers SHALL occur only on cycles where valid and ready are both high (input and output sides independently).
REQ-015 The block SHALL perform 2x2, stride-2 pooling: output (r,c) covers input rows 2r, 2r+1 and columns 2c, 2c+1; the frame yields (IMG_WIDTH/2)*(IMG_HEIGHT/2) outputs.
REQ-016 Column and row counters SHALL advance per accepted pixel; column wraps IMG_WIDTH-1 -> 0 with row increment; row wraps IMG_HEIGHT-1 -> 0.
REQ-017 mode SHALL be sampled on acceptance of pixel (0,0) and held for the whole frame; changes mid-frame SHALL have no effect until the next frame.
REQ-018 Even row, even column: pixel SHALL be held in a pair register; even row, odd column: pair result (max, or DATA_WIDTH+1-bit sum) SHALL be written to line buffer entry col/2.
REQ-019 Odd row, odd column: pair result SHALL be combined with line buffer entry col/2; max mode outputs the max of four; avg mode outputs the DATA_WIDTH+2-bit sum shifted right by 2 (truncation, no rounding).
REQ-020 The result SHALL be registered: out_valid rises the cycle after the fourth pixel of a window is accepted (latency 1).
REQ-021 out_valid and out_data SHALL hold stable until accepted.
REQ-022 in_ready SHALL equal NOT(out_valid AND NOT out_ready); a new result may be loaded in the same cycle the previous one is accepted.
REQ-023 Accepting an input that completes a window while the output register is draining in the same cycle SHALL overwrite it with the new result without loss.
REQ-024 frame_done SHALL pulse for one cycle the cycle after acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the final out_valid rise.
REQ-025 Back-to-back frames SHALL run with no idle cycles required.

Reset
REQ-026 On rst, counters SHALL clear to 0, out_valid and frame_done to 0, out_data to 0, sampled mode to 1 (max).
REQ-027 Line buffer and pair register need not be reset; their stale content SHALL never reach out_data.
REQ-028 Reset mid-frame SHALL discard the partial frame and any pending output; the next accepted pixel is (0,0).
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Package pool_pkg SHALL hold typedef pool_mode_e (POOL_AVG=0, POOL_MAX=1) and width helpers (SUM2_W = DATA_WIDTH+1, SUM4_W = DATA_WIDTH+2).
REQ-031 Sub-module pool_line_buffer SHALL implement the IMG_WIDTH/2 x SUM2_W partial-result store (one write, one read port, combinational read).
REQ-032 No other sub-modules; counters, combine logic and output register reside in pooling_stream.

Verification (bench uses IMG_WIDTH=4, IMG_HEIGHT=4 unless stated)
REQ-033 Max, no stall: rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, mode=1 -> outputs 6,8,14,16; frame_done once.
REQ-034 Avg truncation: window 255,255,255,254, mode=0 -> 254; window 0,0,0,3 -> 0.
REQ-035 Backpressure: out_ready=0 for 5 cycles with result pending -> in_ready=0, out_data stable, no pixel dropped; final stream matches REQ-033.
REQ-036 Mode change mid-frame: mode 1->0 after pixel 3 -> whole frame pooled max; next frame pooled avg.
REQ-037 Reset at pixel 9 of a frame, then full frame -> no output from aborted frame; outputs match REQ-033.
REQ-038 Continuous random valid/ready over 3 frames, random data -> output sequence equals reference model, one frame_done per frame.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and width helpers for the 2x2 stride-2 pooling stream.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int SUM2_W = DEF_DATA_WIDTH + 1;
  localparam int SUM4_W = DEF_DATA_WIDTH + 2;

  function automatic int sum2_w(input int data_width);
    return data_width + 1;
  endfunction

  function automatic int sum4_w(input int data_width);
    return data_width + 2;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-row store of horizontal pair results (max or pair sum), one per output column.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int DEPTH = 14,
  parameter int WIDTH = SUM2_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pooling_stream.sv
// Streaming 2x2 stride-2 max/average pooling over raster-order pixels, one result register.
module pooling_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int S2W = sum2_w(DATA_WIDTH);
  localparam int S4W = sum4_w(DATA_WIDTH);
  localparam int CW  = $clog2(IMG_WIDTH);
  localparam int RW  = $clog2(IMG_HEIGHT);
  localparam int LBD = IMG_WIDTH / 2;
  localparam int LAW = (LBD > 1) ? $clog2(LBD) : 1;

  function automatic logic [S2W-1:0] pair_combine(input pool_mode_e m,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    if (m == POOL_MAX) return (a > b) ? {1'b0, a} : {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Average truncates toward zero: the two low bits of the four-pixel sum are dropped.
  function automatic logic [DATA_WIDTH-1:0] quad_combine(input pool_mode_e m,
                                                         input logic [S2W-1:0] p,
                                                         input logic [S2W-1:0] q);
    logic [S4W-1:0] s;
    if (m == POOL_MAX) return (p > q) ? p[DATA_WIDTH-1:0] : q[DATA_WIDTH-1:0];
    s = {1'b0, p} + {1'b0, q};
    return s[S4W-1:2];
  endfunction

  logic [CW-1:0]         col_p0;
  logic [RW-1:0]         row_p0;
  pool_mode_e            mode_p0;
  logic [DATA_WIDTH-1:0] pair_p0;
  logic [DATA_WIDTH-1:0] res_p1;
  logic                  vld_p1;
  logic                  fdone_p1;

  logic                  accept;
  logic                  col_last;
  logic                  row_last;
  logic                  first_px;
  logic                  lb_we;
  logic                  win_done;
  logic [LAW-1:0]        lb_addr;
  logic [S2W-1:0]        pair_res;
  logic [S2W-1:0]        lb_rdata;
  logic [DATA_WIDTH-1:0] win_res;

  assign in_ready = ~(vld_p1 & ~out_ready);
  assign accept   = in_valid & in_ready;
  assign col_last = (col_p0 == CW'(IMG_WIDTH - 1));
  assign row_last = (row_p0 == RW'(IMG_HEIGHT - 1));
  assign first_px = (col_p0 == '0) && (row_p0 == '0);
  assign lb_addr  = LAW'(col_p0 >> 1);
  assign pair_res = pair_combine(mode_p0, pair_p0, in_data);
  assign lb_we    = accept & ~row_p0[0] & col_p0[0];
  assign win_done = accept & row_p0[0] & col_p0[0];
  assign win_res  = quad_combine(mode_p0, pair_res, lb_rdata);

  pool_line_buffer #(
    .DEPTH (LBD),
    .WIDTH (S2W),
    .AW    (LAW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_res),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Stage p0: position counters, frame mode and left pixel of the current pair
  always_ff @(posedge clk) begin
    if (accept && !col_p0[0]) pair_p0 <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0   <= '0;
      row_p0   <= '0;
      mode_p0  <= POOL_MAX;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      fdone_p1 <= 1'b0;
    end else begin
      if (accept) begin
        if (first_px) mode_p0 <= pool_mode_e'(mode);
        if (col_last) begin
          col_p0 <= '0;
          row_p0 <= row_last ? '0 : row_p0 + 1'b1;
        end else begin
          col_p0 <= col_p0 + 1'b1;
        end
      end
      // Stage p1: result register; a completing window overwrites a draining result
      if (win_done) begin
        vld_p1 <= 1'b1;
        res_p1 <= win_res;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      fdone_p1 <= win_done & row_last & col_last;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = res_p1;
  assign frame_done = fdone_p1;

endmodule
